// File: rtl/ks_note_sequencer_pkg.sv
// Shared definitions for the Karplus-Strong note sequencer.
// Holds the FSM state encoding, the step-entry width helper and the
// default timing constants used by the top level and the step timer.
package ks_note_sequencer_pkg;

    // Sequencer FSM encoding, fixed so software/debug views stay stable.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_PAUSE = 2'd2
    } seq_state_t;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_PRESCALE   = 16;
    localparam int DEF_PLUCK_LEN  = 4;

    // One pattern entry is {rest, period}: rest flag sits in the MSB.
    function automatic int entry_width(input int data_width);
        return data_width + 1;
    endfunction

endpackage

// File: rtl/ks_note_sequencer_timer.sv
// ks_seq_timer: tempo prescaler plus tick counter producing step boundaries.
// Ports: clk_i/rst_i, clear_i (zero both counters), hold_i (freeze both),
//        step_len_i (ticks per step minus one), step_tick_o (one-cycle boundary).
module ks_seq_timer
    import ks_note_sequencer_pkg::*;
#(
    parameter int PRESCALE = DEF_PRESCALE
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clear_i,
    input  logic       hold_i,
    input  logic [7:0] step_len_i,
    output logic       step_tick_o
);

    localparam int PS_W = $clog2(PRESCALE);

    logic [PS_W-1:0] r_presc;
    logic [7:0]      r_tick_cnt;
    logic            w_tick;

    assign w_tick      = !hold_i && (r_presc == PS_W'(PRESCALE - 1));
    // >= rather than == so shortening step_len_i mid-step ends the step
    // on the very next tick instead of waiting for a counter wrap.
    assign step_tick_o = w_tick && (r_tick_cnt >= step_len_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_presc    <= '0;
            r_tick_cnt <= '0;
        end else if (clear_i) begin
            r_presc    <= '0;
            r_tick_cnt <= '0;
        end else if (!hold_i) begin
            if (w_tick) begin
                r_presc    <= '0;
                r_tick_cnt <= step_tick_o ? 8'd0 : r_tick_cnt + 8'd1;
            end else begin
                r_presc <= r_presc + PS_W'(1);
            end
        end
    end

endmodule

// File: rtl/ks_note_sequencer.sv
// ks_note_sequencer: plays a small {rest, period} pattern into ks_string.
// Ports: pattern write (wr_*), transport (start/stop/pause/loop_en/last_step/
//        step_len), outputs period_o/pluck_o/step_o/busy_o/done_o, all registered.
module ks_note_sequencer
    import ks_note_sequencer_pkg::*;
#(
    parameter int NUM_STEPS  = 8,
    parameter int STEP_AW    = 3,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int PRESCALE   = DEF_PRESCALE,
    parameter int PLUCK_LEN  = DEF_PLUCK_LEN
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wr_en_i,
    input  logic [STEP_AW-1:0]    wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  wr_rest_i,
    input  logic                  start_i,
    input  logic                  stop_i,
    input  logic                  pause_i,
    input  logic                  loop_en_i,
    input  logic [STEP_AW-1:0]    last_step_i,
    input  logic [7:0]            step_len_i,
    output logic [DATA_WIDTH-1:0] period_o,
    output logic                  pluck_o,
    output logic [STEP_AW-1:0]    step_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int ENTRY_W = entry_width(DATA_WIDTH);
    localparam int PC_W    = $clog2(PLUCK_LEN + 1);

    logic [ENTRY_W-1:0]    r_mem [NUM_STEPS];
    seq_state_t            r_state;
    seq_state_t            w_nxt_state;
    logic [STEP_AW-1:0]    r_step;
    logic [DATA_WIDTH-1:0] r_period;
    logic                  r_pluck;
    logic [PC_W-1:0]       r_pluck_cnt;
    logic                  r_done;
    logic                  r_busy;

    logic                  w_enter;
    logic [STEP_AW-1:0]    w_enter_idx;
    logic                  w_done;
    logic [ENTRY_W-1:0]    w_entry;
    logic                  w_entry_rest;
    logic                  w_step_tick;
    logic                  w_tmr_clr;
    logic                  w_tmr_hold;

    // Timer only runs while a pattern is active and pause_i is low, so a
    // pause of N cycles shifts every later boundary by exactly N cycles.
    assign w_tmr_clr  = start_i | stop_i;
    assign w_tmr_hold = (r_state == ST_IDLE) | pause_i;

    ks_seq_timer #(
        .PRESCALE (PRESCALE)
    ) u_timer (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clear_i     (w_tmr_clr),
        .hold_i      (w_tmr_hold),
        .step_len_i  (step_len_i),
        .step_tick_o (w_step_tick)
    );

    // Entry read uses the pre-write contents, so a write landing on the
    // step being entered only shows up the next time that step is entered.
    assign w_entry      = r_mem[w_enter_idx];
    assign w_entry_rest = w_entry[ENTRY_W-1];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nxt_state;
        end
    end

    always_comb begin
        w_nxt_state = r_state;
        w_enter     = 1'b0;
        w_enter_idx = r_step;
        w_done      = 1'b0;
        if (stop_i) begin
            w_nxt_state = ST_IDLE;
        end else if (start_i) begin
            w_nxt_state = ST_PLAY;
            w_enter     = 1'b1;
            w_enter_idx = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_nxt_state = ST_IDLE;
                end
                ST_PLAY, ST_PAUSE: begin
                    // A boundary can fire in the cycle pause_i drops while the
                    // state register still reads PAUSE, so both states advance.
                    if (w_step_tick) begin
                        w_nxt_state = ST_PLAY;
                        if (r_step < last_step_i) begin
                            w_enter     = 1'b1;
                            w_enter_idx = r_step + STEP_AW'(1);
                        end else if (loop_en_i) begin
                            w_enter     = 1'b1;
                            w_enter_idx = '0;
                        end else begin
                            w_nxt_state = ST_IDLE;
                            w_done      = 1'b1;
                        end
                    end else begin
                        w_nxt_state = pause_i ? ST_PAUSE : ST_PLAY;
                    end
                end
                default: begin
                    w_nxt_state = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_STEPS; i++) begin
                r_mem[i] <= {1'b1, {DATA_WIDTH{1'b0}}};
            end
            r_step      <= '0;
            r_period    <= '0;
            r_pluck     <= 1'b0;
            r_pluck_cnt <= '0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            if (wr_en_i) begin
                r_mem[wr_addr_i] <= {wr_rest_i, wr_data_i};
            end

            r_done <= w_done;
            r_busy <= (w_nxt_state != ST_IDLE);

            if (w_enter) begin
                r_step <= w_enter_idx;
                if (!w_entry_rest) begin
                    r_period <= w_entry[DATA_WIDTH-1:0];
                end
            end

            // Pulse generator: a non-rest entry reloads the counter, which
            // stretches a pulse already in flight; pause does not touch it.
            if (stop_i) begin
                r_pluck     <= 1'b0;
                r_pluck_cnt <= '0;
            end else if (w_enter && !w_entry_rest) begin
                r_pluck     <= 1'b1;
                r_pluck_cnt <= PC_W'(PLUCK_LEN);
            end else if (r_pluck_cnt != '0) begin
                r_pluck     <= (r_pluck_cnt > PC_W'(1));
                r_pluck_cnt <= r_pluck_cnt - PC_W'(1);
            end
        end
    end

    assign period_o = r_period;
    assign pluck_o  = r_pluck;
    assign step_o   = r_step;
    assign busy_o   = r_busy;
    assign done_o   = r_done;

endmodule

// File: tb/tb_ks_note_sequencer.sv
// Directed bench for ks_note_sequencer with hand-computed expectations.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_ks_note_sequencer;

    localparam int PRESCALE  = 16;
    localparam int PLUCK_LEN = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [2:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic       wr_rest = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       pause = 1'b0;
    logic       loop_en = 1'b0;
    logic [2:0] last_step = '0;
    logic [7:0] step_len = '0;
    logic [7:0] period;
    logic       pluck;
    logic [2:0] step;
    logic       busy;
    logic       done;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ks_note_sequencer #(
        .NUM_STEPS  (8),
        .STEP_AW    (3),
        .DATA_WIDTH (8),
        .PRESCALE   (PRESCALE),
        .PLUCK_LEN  (PLUCK_LEN)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .wr_en_i     (wr_en),
        .wr_addr_i   (wr_addr),
        .wr_data_i   (wr_data),
        .wr_rest_i   (wr_rest),
        .start_i     (start),
        .stop_i      (stop),
        .pause_i     (pause),
        .loop_en_i   (loop_en),
        .last_step_i (last_step),
        .step_len_i  (step_len),
        .period_o    (period),
        .pluck_o     (pluck),
        .step_o      (step),
        .busy_o      (busy),
        .done_o      (done)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input int addr, input int data, input bit rest);
        wr_addr = addr[2:0];
        wr_data = data[7:0];
        wr_rest = rest;
        wr_en   = 1'b1;
        cyc(1);
        wr_en   = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        // Reset state
        cyc(3);
        check("rst_period", period, 0);
        check("rst_pluck", pluck, 0);
        check("rst_step", step, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst = 1'b0;
        cyc(1);

        // Basic non-looping play, 32-cycle steps
        step_len  = 8'd1;
        last_step = 3'd2;
        loop_en   = 1'b0;
        wr(0, 20, 1'b0);
        wr(1, 30, 1'b0);
        wr(2, 40, 1'b0);
        pulse_start();
        check("basic_p0", period, 20);
        check("basic_step0", step, 0);
        check("basic_busy", busy, 1);
        n = 0;
        while (pluck && n < 20) begin
            n++;
            cyc(1);
        end
        check("basic_pluck_len", n, PLUCK_LEN);
        cyc(27);
        check("basic_p0_hold", period, 20);
        cyc(1);
        check("basic_p1", period, 30);
        check("basic_step1", step, 1);
        cyc(31);
        check("basic_p1_hold", period, 30);
        cyc(1);
        check("basic_p2", period, 40);
        cyc(31);
        check("basic_done_early", done, 0);
        check("basic_busy_late", busy, 1);
        cyc(1);
        check("basic_done", done, 1);
        check("basic_busy_end", busy, 0);
        check("basic_period_kept", period, 40);
        cyc(1);
        check("basic_done_1cyc", done, 0);

        // Loop with step 1 as a rest
        wr(1, 99, 1'b1);
        loop_en = 1'b1;
        pulse_start();
        check("loop_s0", step, 0);
        cyc(32);
        check("loop_s1", step, 1);
        check("loop_rest_period", period, 20);
        check("loop_rest_pluck", pluck, 0);
        cyc(16);
        check("loop_rest_pluck_mid", pluck, 0);
        cyc(16);
        check("loop_s2", step, 2);
        check("loop_s2_pluck", pluck, 1);
        cyc(32);
        check("loop_wrap", step, 0);
        check("loop_wrap_period", period, 20);

        // Live write of the step being played
        wr(0, 25, 1'b0);
        check("live_wr_no_effect", period, 20);
        cyc(95);
        check("live_wr_next_pass_step", step, 0);
        check("live_wr_next_pass", period, 25);

        // Pause for 100 cycles early in step 0
        pulse_stop();
        check("stop_busy", busy, 0);
        pulse_start();
        cyc(2);
        pause = 1'b1;
        cyc(1);
        check("pause_keeps_pluck", pluck, 1);
        cyc(1);
        check("pause_pluck_ends", pluck, 0);
        cyc(48);
        check("pause_busy", busy, 1);
        cyc(50);
        pause = 1'b0;
        cyc(29);
        check("pause_shift_pre", step, 0);
        cyc(1);
        check("pause_shift", step, 1);

        // Start and stop together: stop wins
        start = 1'b1;
        stop  = 1'b1;
        cyc(1);
        start = 1'b0;
        stop  = 1'b0;
        check("startstop_busy", busy, 0);

        // Restart during step 2
        pulse_start();
        cyc(64);
        check("restart_at_s2", step, 2);
        cyc(5);
        check("restart_pluck_off", pluck, 0);
        pulse_start();
        check("restart_step", step, 0);
        check("restart_pluck", pluck, 1);
        check("restart_period", period, 25);
        pulse_stop();
        check("stop_clears_pluck", pluck, 0);
        check("stop_busy2", busy, 0);

        // Lower step_len mid-step
        step_len = 8'd10;
        pulse_start();
        cyc(40);
        step_len = 8'd0;
        cyc(7);
        check("len_drop_pre", step, 0);
        cyc(1);
        check("len_drop_next_tick", step, 1);

        // Lower last_step below the current step
        last_step = 3'd0;
        loop_en   = 1'b0;
        cyc(15);
        check("last_low_pre_busy", busy, 1);
        check("last_low_pre_done", done, 0);
        cyc(1);
        check("last_low_done", done, 1);
        check("last_low_busy", busy, 0);
        check("last_low_period", period, 25);

        // Asynchronous reset mid-play with pluck high at step 3
        wr(3, 50, 1'b0);
        last_step = 3'd3;
        loop_en   = 1'b1;
        pulse_start();
        cyc(48);
        check("prerst_step", step, 3);
        check("prerst_pluck", pluck, 1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_period", period, 0);
        check("arst_pluck", pluck, 0);
        check("arst_step", step, 0);
        check("arst_busy", busy, 0);
        #2;
        rst = 1'b0;
        cyc(1);
        pulse_start();
        check("postrst_busy", busy, 1);
        check("postrst_step", step, 0);
        check("postrst_rest_pluck", pluck, 0);
        check("postrst_period", period, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
